// File: rtl/jt51_kc_finder.sv
// Finds the largest KC/KF whose phase step does not exceed a target, by successive approximation over the phase ROM.
// Fixed 39 cen-cycle latency from accepted start to done; start is ignored unless idle.
module jt51_kc_finder (
    input  logic        rst,
    input  logic        clk,
    input  logic        cen,
    input  logic        start,
    input  logic [19:0] step,
    output logic [9:0]  rom_addr,
    input  logic [11:0] rom_data,
    output logic        busy,
    output logic        done,
    output logic [6:0]  kc,
    output logic [5:0]  kf,
    output logic        unf,
    output logic        ovf
);
    typedef enum logic [2:0] {S_IDLE, S_OVF, S_OCT, S_SRCH, S_DONE} state_t;

    state_t      state, state_nx;
    logic [19:0] step_q;
    logic        phase;
    logic [3:0]  cnt;
    logic [2:0]  oct;
    logic        found;
    logic [9:0]  idx;

    logic [2:0]  po;
    logic [17:0] base;
    logic [19:0] base20;
    logic [9:0]  trial;
    logic [9:0]  idx_nx;
    logic        oct_hit;

    // Note codes skip every fourth value, so the linear index is spread as n + n/3.
    function automatic logic [3:0] code_of(input logic [3:0] n);
        return n + n / 4'd3;
    endfunction

    function automatic logic [9:0] addr_of(input logic [9:0] t);
        return {code_of(t[9:6]), t[5:0]};
    endfunction

    always_comb begin
        po = oct;
        if (state == S_OVF)
            po = 3'd7;
        else if (state == S_OCT)
            po = cnt[2:0];
        if (po >= 3'd2)
            base = {6'd0, rom_data} << (po - 3'd2);
        else
            base = {6'd0, rom_data} >> (3'd2 - po);
        base20  = {2'b00, base};
        trial   = idx | (10'd1 << cnt);
        idx_nx  = ((trial <= 10'd767) && (base20 <= step_q)) ? trial : idx;
        oct_hit = step_q >= base20;
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= S_IDLE;
        else if (cen)
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (start) state_nx = S_OVF;
            S_OVF:  if (phase) state_nx = S_OCT;
            S_OCT:  if (phase && cnt == 4'd0) state_nx = S_SRCH;
            S_SRCH: if (phase && cnt == 4'd0) state_nx = S_DONE;
            S_DONE: state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            step_q   <= 20'd0;
            phase    <= 1'b0;
            cnt      <= 4'd0;
            oct      <= 3'd0;
            found    <= 1'b0;
            idx      <= 10'd0;
            rom_addr <= 10'd0;
            busy     <= 1'b0;
            done     <= 1'b0;
            kc       <= 7'd0;
            kf       <= 6'd0;
            unf      <= 1'b0;
            ovf      <= 1'b0;
        end else if (cen) begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        step_q   <= step;
                        unf      <= 1'b0;
                        ovf      <= 1'b0;
                        busy     <= 1'b1;
                        phase    <= 1'b0;
                        rom_addr <= {4'd14, 6'd63};
                    end
                end
                S_OVF: begin
                    phase <= ~phase;
                    if (phase) begin
                        ovf      <= step_q > base20;
                        cnt      <= 4'd7;
                        found    <= 1'b0;
                        oct      <= 3'd0;
                        rom_addr <= 10'd0;
                    end
                end
                S_OCT: begin
                    phase <= ~phase;
                    if (phase) begin
                        // Scanning downward, the first qualifying octave is the highest.
                        if (!found && oct_hit) begin
                            found <= 1'b1;
                            oct   <= cnt[2:0];
                        end
                        if (cnt == 4'd0) begin
                            unf      <= !(found || oct_hit);
                            cnt      <= 4'd9;
                            idx      <= 10'd0;
                            rom_addr <= addr_of(10'd512);
                        end else begin
                            cnt <= cnt - 4'd1;
                        end
                    end
                end
                S_SRCH: begin
                    phase <= ~phase;
                    if (phase) begin
                        idx <= idx_nx;
                        if (cnt == 4'd0) begin
                            busy <= 1'b0;
                            done <= 1'b1;
                            if (ovf) begin
                                kc <= 7'h7E;
                                kf <= 6'd63;
                            end else if (unf) begin
                                kc <= 7'd0;
                                kf <= 6'd0;
                            end else begin
                                kc <= {oct, code_of(idx_nx[9:6])};
                                kf <= idx_nx[5:0];
                            end
                        end else begin
                            cnt      <= cnt - 4'd1;
                            rom_addr <= addr_of(idx_nx | (10'd1 << (cnt - 4'd1)));
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_jt51_kc_finder.sv
// Bench for jt51_kc_finder: registered ROM (1024 + addr), directed and random targets against a brute-force model.
module tb_jt51_kc_finder;
    logic        rst, clk, cen, start;
    logic [19:0] step_in;
    logic [9:0]  rom_addr;
    logic [11:0] rom_data;
    logic        busy, done, unf, ovf;
    logic [6:0]  kc;
    logic [5:0]  kf;

    int n_cmp = 0;
    int n_bad = 0;
    bit cen_rand = 0;

    jt51_kc_finder dut (
        .rst(rst), .clk(clk), .cen(cen), .start(start), .step(step_in),
        .rom_addr(rom_addr), .rom_data(rom_data), .busy(busy), .done(done),
        .kc(kc), .kf(kf), .unf(unf), .ovf(ovf)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    always @(posedge clk)
        if (cen) rom_data <= 12'd1024 + {2'b00, rom_addr};

    initial begin
        cen = 1;
        forever begin
            @(negedge clk);
            cen = cen_rand ? 1'($urandom % 2) : 1'b1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int base_of(input int o, input int a);
        int r;
        r = 1024 + a;
        return (o >= 2) ? (r << (o - 2)) : (r >> (2 - o));
    endfunction

    // Exhaustive search over all valid (octave, index) pairs.
    function automatic void model(input int s, output int ekc, output int ekf,
                                  output int eunf, output int eovf);
        int oct, best, best_b, n, code, a, b;
        eovf = (s > base_of(7, 14 * 64 + 63)) ? 1 : 0;
        eunf = 0;
        oct = -1;
        for (int o = 0; o < 8; o++)
            if (s >= base_of(o, 0)) oct = o;
        if (eovf == 1) begin
            ekc = 126; ekf = 63;
        end else if (oct < 0) begin
            eunf = 1; ekc = 0; ekf = 0;
        end else begin
            best = 0; best_b = -1;
            for (int i = 0; i < 768; i++) begin
                n = i / 64;
                a = (n + n / 3) * 64 + i % 64;
                b = base_of(oct, a);
                if (b <= s && b > best_b) begin
                    best_b = b; best = i;
                end
            end
            n = best / 64;
            ekc = oct * 16 + n + n / 3;
            ekf = best % 64;
        end
    endfunction

    task automatic run(input int s, input bit noise);
        int ekc, ekf, eunf, eovf, c, g;
        bit seen, to;
        logic [6:0] kc_done;
        model(s, ekc, ekf, eunf, eovf);
        @(negedge clk);
        start = 1;
        step_in = s[19:0];
        g = 0;
        do begin
            @(posedge clk);
            g++;
        end while (!cen && g < 100);
        to = !cen;
        @(negedge clk);
        start = 0;
        chk("accept_timeout", 32'(to), 0);
        chk("busy_after_accept", 32'(busy), 1);
        c = 0;
        seen = 0;
        for (int k = 0; k < 1000 && !seen; k++) begin
            if (noise && c < 30) begin
                start = 1'($urandom % 3 == 0);
                step_in = 20'($urandom);
            end else begin
                start = 0;
            end
            @(posedge clk);
            if (cen) c++;
            @(negedge clk);
            if (done) seen = 1;
        end
        start = 0;
        chk($sformatf("done_seen s=%0d", s), 32'(seen), 1);
        chk($sformatf("latency s=%0d", s), c + 1, 39);
        chk($sformatf("kc s=%0d", s), 32'(kc), ekc);
        chk($sformatf("kf s=%0d", s), 32'(kf), ekf);
        chk($sformatf("unf s=%0d", s), 32'(unf), eunf);
        chk($sformatf("ovf s=%0d", s), 32'(ovf), eovf);
        chk($sformatf("busy_at_done s=%0d", s), 32'(busy), 0);
        kc_done = kc;
        repeat (3) @(negedge clk);
        chk($sformatf("kc_hold s=%0d", s), 32'(kc), 32'(kc_done));
    endtask

    initial begin
        int dir[10];
        bit seen;
        int c;
        dir = '{4372, 4375, 2048, 2047, 100, 70000, 63456, 63457, 0, 1048575};
        rst = 1; start = 0; step_in = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_kc", 32'(kc), 0);
        chk("rst_kf", 32'(kf), 0);
        chk("rst_unf", 32'(unf), 0);
        chk("rst_ovf", 32'(ovf), 0);
        chk("rst_addr", 32'(rom_addr), 0);
        rst = 0;

        foreach (dir[i]) run(dir[i], 0);
        for (int i = 0; i < 15; i++) run(int'($urandom_range(0, 70000)), 0);

        cen_rand = 1;
        for (int i = 0; i < 10; i++) run(int'($urandom_range(0, 70000)), 1'(i % 2));

        // Reset in the middle of a search must abort with no done pulse.
        @(negedge clk);
        start = 1;
        step_in = 20'd4372;
        c = 0;
        for (int k = 0; k < 500 && c < 20; k++) begin
            @(posedge clk);
            if (cen) c++;
            @(negedge clk);
            start = 0;
        end
        rst = 1;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_done", 32'(done), 0);
        chk("midrst_kc", 32'(kc), 0);
        chk("midrst_kf", 32'(kf), 0);
        chk("midrst_addr", 32'(rom_addr), 0);
        rst = 0;
        seen = 0;
        repeat (120) begin
            @(negedge clk);
            if (done || busy) seen = 1;
        end
        chk("midrst_no_done", 32'(seen), 0);

        run(4372, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
